// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: shared game state encoding and score width
package game_ctrl_pkg;
  typedef enum logic [1:0] {MENU = 2'b00, READY = 2'b01, GAME = 2'b10, SCORE = 2'b11} state_e;
  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
endpackage

// File: rtl/game_ctrl_sec_tick.sv
// sec_tick: one-cycle pulse every CLK_PER_SEC cycles, restartable via clear
module sec_tick #(
  parameter int CLK_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(CLK_PER_SEC - 1);
  always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: MENU/READY/GAME/SCORE sequencer with score, high score and countdown
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int CLK_PER_SEC = 100000000,
  parameter int READY_TIME  = 3,
  parameter int SCORE_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               click,
  input  logic               hit,
  input  logic               end_of_time,
  output logic [1:0]         state_out,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         countdown,
  output logic               new_record
);
  state_e state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, high_q, high_d, hit_score;
  logic [1:0] cd_q, cd_d;
  logic [7:0] hold_q, hold_d;
  logic nr_q, nr_d, click_q, armed_q, click_rise, tick, clear;
  // armed_q blocks a click that was already held when reset released
  assign click_rise = click && !click_q && armed_q;
  assign hit_score  = (hit && score_q != SCORE_MAX) ? score_q + 1'b1 : score_q;
  assign clear      = state_q == MENU || state_q == GAME || state_d != state_q;
  sec_tick #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (.clk(clk), .rst(rst), .clear(clear), .tick(tick));
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    cd_d    = cd_q;
    nr_d    = nr_q;
    hold_d  = '0;
    case (state_q)
      MENU: if (click_rise) begin
        state_d = READY;
        score_d = '0;
        cd_d    = 2'(READY_TIME);
      end
      READY: if (tick) begin
        cd_d    = cd_q - 2'd1;
        state_d = (cd_q == 2'd1) ? GAME : READY;
      end
      GAME: begin
        score_d = hit_score;
        if (end_of_time) begin
          state_d = SCORE;
          nr_d    = hit_score > high_q;
          high_d  = (hit_score > high_q) ? hit_score : high_q;
        end
      end
      SCORE: begin
        hold_d = (tick && hold_q < 8'(SCORE_HOLD)) ? hold_q + 8'd1 : hold_q;
        if (click_rise && hold_q >= 8'(SCORE_HOLD)) begin
          state_d = MENU;
          nr_d    = 1'b0;
        end
      end
      default: state_d = MENU;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= MENU;
      score_q <= '0;
      high_q  <= '0;
      cd_q    <= '0;
      nr_q    <= 1'b0;
      hold_q  <= '0;
      click_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      cd_q    <= cd_d;
      nr_q    <= nr_d;
      hold_q  <= hold_d;
      click_q <= click;
      armed_q <= armed_q || !click;
    end
  assign state_out  = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign countdown  = cd_q;
  assign new_record = nr_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed stimulus, elapsed-time reference model checked every cycle
module tb_game_ctrl;
  localparam int CPS = 10, RT = 3, SH = 2;
  logic clk = 1'b0, rst = 1'b1, click = 1'b0, hit = 1'b0, eot = 1'b0;
  logic [1:0] state_out, countdown;
  logic [7:0] score, high_score;
  logic new_record;
  int tests = 0, fails = 0;
  int m_st, m_sc, m_hi, m_nr, m_t, m_prev, m_arm;

  game_ctrl #(.CLK_PER_SEC(CPS), .READY_TIME(RT), .SCORE_HOLD(SH)) dut (
    .clk(clk), .rst(rst), .click(click), .hit(hit), .end_of_time(eot),
    .state_out(state_out), .score(score), .high_score(high_score),
    .countdown(countdown), .new_record(new_record));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Model: time spent in the current state decides countdown and transitions
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_st = 0; m_sc = 0; m_hi = 0; m_nr = 0; m_t = 0; m_prev = 0; m_arm = 0;
    end else begin
      int nxt;
      bit rise;
      rise = click && !m_prev && m_arm;
      nxt = m_st;
      case (m_st)
        0: if (rise) begin nxt = 1; m_sc = 0; end
        1: if (m_t == RT * CPS - 1) nxt = 2;
        2: begin
          if (hit && m_sc < 255) m_sc++;
          if (eot) begin
            nxt = 3;
            m_nr = (m_sc > m_hi) ? 1 : 0;
            if (m_sc > m_hi) m_hi = m_sc;
          end
        end
        default: if (rise && m_t >= SH * CPS) begin nxt = 0; m_nr = 0; end
      endcase
      m_t = (nxt != m_st) ? 0 : m_t + 1;
      m_st = nxt;
      m_prev = click;
      if (!click) m_arm = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("state", state_out, m_st);
      chk("score", score, m_sc);
      chk("high", high_score, m_hi);
      chk("cd", countdown, (m_st == 1) ? RT - m_t / CPS : 0);
      chk("nr", new_record, m_nr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_click();
    click = 1'b1; cyc(1); click = 1'b0; cyc(1);
  endtask

  task automatic wait_state(input int s);
    int n = 0;
    while (state_out != 2'(s) && n < 200) begin cyc(1); n++; end
    chk("wait_state", state_out, s);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin hit = 1'b1; cyc(1); hit = 1'b0; cyc(1); end
  endtask

  task automatic end_game();
    eot = 1'b1; cyc(1); eot = 1'b0; cyc(1);
  endtask

  task automatic leave_score();
    cyc(25); pulse_click(); wait_state(0);
  endtask

  initial begin
    click = 1'b1;
    cyc(3);
    chk("rst_state", state_out, 0);
    chk("rst_cd", countdown, 0);
    rst = 1'b0;
    cyc(4);
    chk("held_click_ignored", state_out, 0);
    click = 1'b0; cyc(1);
    hit = 1'b1; eot = 1'b1; cyc(1); hit = 1'b0; eot = 1'b0; cyc(1);
    chk("menu_hit_ignored", score, 0);
    click = 1'b1; cyc(1); click = 1'b0;
    chk("ready_entry", state_out, 1);
    chk("cd3", countdown, 3);
    cyc(10); chk("cd2", countdown, 2);
    cyc(10); chk("cd1", countdown, 1);
    cyc(10); chk("game_entry", state_out, 2);
    chk("cd0", countdown, 0);
    hits(4);
    hit = 1'b1; eot = 1'b1; cyc(1); hit = 1'b0; eot = 1'b0;
    chk("g1_state", state_out, 3);
    chk("g1_score", score, 5);
    chk("g1_high", high_score, 5);
    chk("g1_nr", new_record, 1);
    cyc(3); pulse_click(); cyc(2);
    chk("early_click", state_out, 3);
    cyc(20);
    click = 1'b1; cyc(1);
    chk("score_exit", state_out, 0);
    chk("nr_clear", new_record, 0);
    cyc(5);
    chk("held_one_event", state_out, 0);
    click = 1'b0; cyc(2);
    pulse_click(); wait_state(2); hits(3); end_game();
    chk("g2_score", score, 3);
    chk("g2_high", high_score, 5);
    chk("g2_nr", new_record, 0);
    leave_score();
    pulse_click(); wait_state(2); hits(5); end_game();
    chk("g3_equal_nr", new_record, 0);
    chk("g3_high", high_score, 5);
    leave_score();
    pulse_click(); wait_state(2); hits(300);
    chk("sat_score", score, 255);
    rst = 1'b1; #1;
    chk("async_state", state_out, 0);
    chk("async_high", high_score, 0);
    chk("async_score", score, 0);
    cyc(2); rst = 1'b0; cyc(3);
    chk("post_rst_state", state_out, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
